// File: rtl/branch_resolver.sv
// In-order branch resolution queue: checks fetch-time predictions against execute
// outcomes, flushes on mispredict and feeds training info back to the predictor.
module branch_resolver #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rstn_h,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [ADDR_W-1:0]            pred_pc,
    input  logic [ADDR_W-1:0]            pred_target,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic [ADDR_W-1:0]            res_target,
    output logic                         flush,
    output logic [ADDR_W-1:0]            redirect_pc,
    output logic [1:0]                   upd_cond,
    output logic                         upd_act_taken,
    output logic                         upd_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic                         res_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);
    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [OccW-1:0]   occ_q, occ_d;
    logic              flush_q;
    logic [ADDR_W-1:0] redirect_q;
    logic [1:0]        upd_cond_q;
    logic              upd_act_q, upd_pred_q, res_err_q;

    logic              mem_taken  [DEPTH];
    logic [ADDR_W-1:0] mem_pc     [DEPTH];
    logic [ADDR_W-1:0] mem_target [DEPTH];

    logic              push, pop, mispredict, empty_res;
    logic              head_taken;
    logic [ADDR_W-1:0] head_pc, head_target, redirect_calc;

    // Ready depends only on registered state; a same-cycle pop never frees the slot.
    assign pred_ready = (state_q == StRun) && (occ_q != OccW'(DEPTH));

    assign head_taken  = mem_taken[head_q];
    assign head_pc     = mem_pc[head_q];
    assign head_target = mem_target[head_q];

    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && (state_q == StRun) && (occ_q != '0);
    assign empty_res  = res_valid && (state_q == StRun) && (occ_q == '0);
    assign mispredict = pop && ((res_taken != head_taken) ||
                                (res_taken && head_taken && (res_target != head_target)));
    assign redirect_calc = res_taken ? res_target : head_pc + ADDR_W'(4);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        unique case (state_q)
            StRun: begin
                if (mispredict) begin
                    state_d = StFlush;
                    cnt_d   = CntW'(FLUSH_CYCLES - 1);
                    head_d  = '0;
                    tail_d  = '0;
                    occ_d   = '0;
                end else begin
                    if (push) tail_d = tail_q + PtrW'(1);
                    if (pop)  head_d = head_q + PtrW'(1);
                    if (push && !pop)      occ_d = occ_q + OccW'(1);
                    else if (pop && !push) occ_d = occ_q - OccW'(1);
                end
            end
            StFlush: begin
                if (cnt_q == '0) state_d = StRun;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            upd_cond_q <= 2'b00;
            upd_act_q  <= 1'b0;
            upd_pred_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            flush_q    <= mispredict;
            if (mispredict) redirect_q <= redirect_calc;
            upd_cond_q <= pop ? 2'b01 : 2'b00;
            if (pop) begin
                upd_act_q  <= res_taken;
                upd_pred_q <= head_taken;
            end
            if (empty_res) res_err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push && !mispredict) begin
            mem_taken[tail_q]  <= pred_taken;
            mem_pc[tail_q]     <= pred_pc;
            mem_target[tail_q] <= pred_target;
        end
    end

    assign flush          = flush_q;
    assign redirect_pc    = redirect_q;
    assign upd_cond       = upd_cond_q;
    assign upd_act_taken  = upd_act_q;
    assign upd_pred_taken = upd_pred_q;
    assign inflight       = occ_q;
    assign res_err        = res_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, ADDR_W=32, FLUSH_CYCLES=2).
module tb_branch_resolver;

    logic        clk;
    logic        rstn_h;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_pc, pred_target;
    logic        pred_ready;
    logic        res_valid, res_taken;
    logic [31:0] res_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [1:0]  upd_cond;
    logic        upd_act_taken, upd_pred_taken;
    logic [2:0]  inflight;
    logic        res_err;

    int tests;
    int fails;

    branch_resolver #(.DEPTH(4), .ADDR_W(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rstn_h(rstn_h),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush(flush), .redirect_pc(redirect_pc), .upd_cond(upd_cond),
        .upd_act_taken(upd_act_taken), .upd_pred_taken(upd_pred_taken),
        .inflight(inflight), .res_err(res_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
    task automatic do_cycle(input logic pv, input logic pt, input logic [31:0] ppc,
                            input logic [31:0] ptgt, input logic rv, input logic rt,
                            input logic [31:0] rtgt);
        pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptgt;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        @(posedge clk); #1;
        pred_valid = 1'b0; res_valid = 1'b0;
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rstn_h = 1'b0;
        pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
        res_valid = 0; res_taken = 0; res_target = 0;
        #3;
        tests++;
        if ({flush, redirect_pc, upd_cond, upd_act_taken, upd_pred_taken, inflight, res_err}
            !== 41'h0) begin
            fails++;
            $display("FAIL reset_outputs: flush=%b redir=%h cond=%b act=%b pred=%b inf=%0d err=%b",
                     flush, redirect_pc, upd_cond, upd_act_taken, upd_pred_taken, inflight,
                     res_err);
        end
        #20 rstn_h = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (pred_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", pred_ready);
        end
    endtask

    task automatic test_correct();
        logic [31:0] tg;
        for (int i = 1; i <= 3; i++)
            do_cycle(1'b1, 1'b1, 32'h100 * i, 32'h100 * i + 32'h80, 1'b0, 1'b0, 32'h0);
        tests++;
        if (inflight !== 3'd3) begin
            fails++; $display("FAIL correct_fill: inflight %0d want 3", inflight);
        end
        for (int i = 1; i <= 3; i++) begin
            tg = 32'h100 * i + 32'h80;
            do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, tg);
            tests++;
            if (upd_cond !== 2'b01 || flush !== 1'b0 || upd_act_taken !== 1'b1 ||
                upd_pred_taken !== 1'b1 || inflight !== 3'(3 - i)) begin
                fails++;
                $display("FAIL correct_pop%0d: cond=%b flush=%b act=%b pred=%b inf=%0d want 01/0/1/1/%0d",
                         i, upd_cond, flush, upd_act_taken, upd_pred_taken, inflight, 3 - i);
            end
        end
        idle();
        tests++;
        if (upd_cond !== 2'b00 || flush !== 1'b0) begin
            fails++; $display("FAIL correct_idle: cond=%b flush=%b want 00/0", upd_cond, flush);
        end
    endtask

    task automatic test_mispredict_dir();
        do_cycle(1'b1, 1'b0, 32'h1000, 32'h1040, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2000);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h2000 || upd_cond !== 2'b01 ||
            upd_act_taken !== 1'b1 || upd_pred_taken !== 1'b0 || pred_ready !== 1'b0 ||
            inflight !== 3'd0) begin
            fails++;
            $display("FAIL mispred_n1: flush=%b redir=%h cond=%b act=%b pred=%b rdy=%b inf=%0d",
                     flush, redirect_pc, upd_cond, upd_act_taken, upd_pred_taken, pred_ready,
                     inflight);
        end
        idle();
        tests++;
        if (flush !== 1'b0 || pred_ready !== 1'b0 || redirect_pc !== 32'h2000) begin
            fails++;
            $display("FAIL mispred_n2: flush=%b rdy=%b redir=%h want 0/0/2000",
                     flush, pred_ready, redirect_pc);
        end
        idle();
        tests++;
        if (pred_ready !== 1'b1) begin
            fails++; $display("FAIL mispred_n3: rdy=%b want 1", pred_ready);
        end
    endtask

    task automatic test_fallthrough();
        do_cycle(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h44) begin
            fails++; $display("FAIL fallthru_44: flush=%b redir=%h want 1/44", flush, redirect_pc);
        end
        idle(); idle();
        do_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
            fails++; $display("FAIL fallthru_wrap: flush=%b redir=%h want 1/0", flush, redirect_pc);
        end
        idle(); idle();
    endtask

    task automatic test_full_wrap();
        logic [32:0] q[$];
        logic [32:0] e;
        logic        tk;
        int          k;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            tk = (k % 3) != 0;
            do_cycle(1'b1, tk, 32'h1000 + 32'(k) * 32'h10, 32'h2000 + 32'(k) * 32'h10,
                     1'b0, 1'b0, 32'h0);
            q.push_back({tk, 32'h2000 + 32'(k) * 32'h10});
            k++;
        end
        tests++;
        if (inflight !== 3'd4 || pred_ready !== 1'b0) begin
            fails++; $display("FAIL full: inf=%0d rdy=%b want 4/0", inflight, pred_ready);
        end
        e = q.pop_front();
        do_cycle(1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1, e[32], e[31:0]);
        tests++;
        if (inflight !== 3'd3 || flush !== 1'b0 || upd_cond !== 2'b01 ||
            upd_pred_taken !== e[32]) begin
            fails++;
            $display("FAIL full_pushpop: inf=%0d flush=%b cond=%b pred=%b want 3/0/01/%b",
                     inflight, flush, upd_cond, upd_pred_taken, e[32]);
        end
        for (int i = 0; i < 6; i++) begin
            tk = (k % 3) != 0;
            e = q.pop_front();
            do_cycle(1'b1, tk, 32'h1000 + 32'(k) * 32'h10, 32'h2000 + 32'(k) * 32'h10,
                     1'b1, e[32], e[31:0]);
            q.push_back({tk, 32'h2000 + 32'(k) * 32'h10});
            k++;
            tests++;
            if (inflight !== 3'd3 || flush !== 1'b0 || upd_cond !== 2'b01 ||
                upd_pred_taken !== e[32] || upd_act_taken !== e[32]) begin
                fails++;
                $display("FAIL wrap_step%0d: inf=%0d flush=%b cond=%b pred=%b act=%b want 3/0/01/%b",
                         i, inflight, flush, upd_cond, upd_pred_taken, upd_act_taken, e[32]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            e = q.pop_front();
            do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, e[32], e[31:0]);
            tests++;
            if (inflight !== 3'(2 - i) || flush !== 1'b0 || upd_pred_taken !== e[32]) begin
                fails++;
                $display("FAIL drain%0d: inf=%0d flush=%b pred=%b want %0d/0/%b",
                         i, inflight, flush, upd_pred_taken, 2 - i, e[32]);
            end
        end
    endtask

    task automatic test_target_mismatch();
        do_cycle(1'b1, 1'b1, 32'h4F0, 32'h500, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h504);
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h504) begin
            fails++; $display("FAIL tgt_mis: flush=%b redir=%h want 1/504", flush, redirect_pc);
        end
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 1'b1, 32'h20);
            tests++;
            if (inflight !== 3'd0 || upd_cond !== 2'b00 || flush !== 1'b0 || res_err !== 1'b0)
            begin
                fails++;
                $display("FAIL flush_ignore%0d: inf=%0d cond=%b flush=%b err=%b want 0/00/0/0",
                         i, inflight, upd_cond, flush, res_err);
            end
        end
        tests++;
        if (pred_ready !== 1'b1) begin
            fails++; $display("FAIL flush_exit: rdy=%b want 1", pred_ready);
        end
    endtask

    task automatic test_res_err();
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tests++;
        if (res_err !== 1'b1 || upd_cond !== 2'b00 || flush !== 1'b0) begin
            fails++;
            $display("FAIL res_err_set: err=%b cond=%b flush=%b want 1/00/0", res_err, upd_cond, flush);
        end
        idle(); idle();
        tests++;
        if (res_err !== 1'b1) begin
            fails++; $display("FAIL res_err_sticky: err=%b want 1", res_err);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_cycle(1'b1, 1'b0, 32'h1000, 32'h1040, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3000);
        tests++;
        if (flush !== 1'b1) begin
            fails++; $display("FAIL pre_reset_flush: flush=%b want 1", flush);
        end
        #2 rstn_h = 1'b0;
        #1;
        tests++;
        if ({flush, redirect_pc, upd_cond, upd_act_taken, upd_pred_taken, inflight, res_err}
            !== 41'h0) begin
            fails++;
            $display("FAIL async_reset: flush=%b redir=%h cond=%b act=%b pred=%b inf=%0d err=%b",
                     flush, redirect_pc, upd_cond, upd_act_taken, upd_pred_taken, inflight,
                     res_err);
        end
        #3 rstn_h = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (pred_ready !== 1'b1 || inflight !== 3'd0 || flush !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: rdy=%b inf=%0d flush=%b want 1/0/0", pred_ready, inflight, flush);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_correct();
        test_mispredict_dir();
        test_fallthrough();
        test_full_wrap();
        test_target_mismatch();
        test_res_err();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
